// File: rtl/act_unit_pipe_if.sv
//============================================================================
// Module      : act_unit_pipe_if
// Description : Input/output beat stream of the FP32 activation pipeline.
// Revision    : 1.0
//============================================================================
`timescale 1ns/1ps
`default_nettype none

interface act_unit_pipe_if #(
    parameter int LANES = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [1:0]            mode;
    logic [32*LANES-1:0]   data_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [32*LANES-1:0]   data_o;

    modport master (
        output in_valid, mode, data_in, out_ready,
        input  in_ready, out_valid, data_o
    );

    modport slave (
        input  in_valid, mode, data_in, out_ready,
        output in_ready, out_valid, data_o
    );
endinterface

`default_nettype wire

// File: rtl/act_unit_pipe.sv
//============================================================================
// Module      : act_unit_pipe
// Description : Two-stage pipelined FP32 activation (pass/ReLU/leaky/clip).
//               Define ACT_UNIT_STATS_EN to add the neg_count/stats_clr port.
// Revision    : 1.0
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module act_unit_pipe #(
    parameter int          LANES     = 4,
    parameter logic [31:0] SLOPE_RST = 32'h3DCCCCCD,
    parameter logic [31:0] CLIP_RST  = 32'h40C00000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_we,
    input  logic        cfg_addr,
    input  logic [31:0] cfg_wdata,
    output logic        cfg_ready,
`ifdef ACT_UNIT_STATS_EN
    input  logic        stats_clr,
    output logic [31:0] neg_count,
`endif
    act_unit_pipe_if.slave s
);

    localparam logic [31:0] c_qnan = 32'h7FC00000;
    localparam logic [1:0]  c_mode_pass  = 2'd0;
    localparam logic [1:0]  c_mode_relu  = 2'd1;
    localparam logic [1:0]  c_mode_leaky = 2'd2;

    logic                 r_s1_valid, r_s2_valid;
    logic [32*LANES-1:0]  r_s1_data, r_s2_data;
    logic [1:0]           r_s1_mode;
    logic [LANES-1:0]     r_s1_nan, r_s1_zero, r_s1_neg;
    logic [31:0]          r_slope, r_clip;

    logic                 w_s2_load, w_s1_load, w_in_ready, w_accept;
    logic [LANES-1:0]     w_in_nan, w_in_zero, w_in_neg;
    logic [32*LANES-1:0]  w_res;

    // Round-to-nearest-even multiply; subnormal operands and results flush to signed zero.
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic        sgn, a_inf, b_inf, b_nan, a_z, b_z;
        logic [47:0] prod;
        logic [22:0] mant;
        logic        grd, stk;
        logic [9:0]  exp0, exp1;
        logic [23:0] mant_r;
        sgn   = a[31] ^ b[31];
        a_inf = (a[30:23] == 8'hFF);
        b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        a_z   = (a[30:23] == 8'h00);
        b_z   = (b[30:23] == 8'h00);
        prod  = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        if (prod[47]) begin
            mant = prod[46:24];
            grd  = prod[23];
            stk  = |prod[22:0];
            exp0 = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd126;
        end else begin
            mant = prod[45:23];
            grd  = prod[22];
            stk  = |prod[21:0];
            exp0 = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
        end
        mant_r = {1'b0, mant} + {23'd0, grd & (stk | mant[0])};
        exp1   = exp0 + {9'd0, mant_r[23]};
        if (b_nan || ((a_inf || b_inf) && (a_z || b_z)))
            fp_mul = c_qnan;
        else if (a_inf || b_inf)
            fp_mul = {sgn, 8'hFF, 23'd0};
        else if (a_z || b_z || exp1[9] || (exp1 == 10'd0))
            fp_mul = {sgn, 31'd0};
        else if (exp1 >= 10'd255)
            fp_mul = {sgn, 8'hFF, 23'd0};
        else
            fp_mul = {sgn, exp1[7:0], mant_r[22:0]};
    endfunction

    assign w_s2_load  = ~r_s2_valid | s.out_ready;
    assign w_s1_load  = w_s2_load | ~r_s1_valid;
    assign w_in_ready = ~r_s1_valid | ~r_s2_valid | s.out_ready;
    assign w_accept   = s.in_valid & w_in_ready;

    assign s.in_ready  = w_in_ready;
    assign s.out_valid = r_s2_valid;
    assign s.data_o    = r_s2_data;
    // An incoming beat blocks config so no accepted beat can see a mid-flight change.
    assign cfg_ready   = ~r_s1_valid & ~r_s2_valid & ~s.in_valid;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [31:0] w_din, w_x, w_prod, w_lane;
        logic        w_pos;

        assign w_din        = s.data_in[32*k +: 32];
        assign w_in_nan[k]  = (w_din[30:23] == 8'hFF) && (w_din[22:0] != 23'd0);
        assign w_in_zero[k] = (w_din[30:0] == 31'd0);
        assign w_in_neg[k]  = w_din[31] & ~w_in_zero[k] & ~w_in_nan[k];

        assign w_x    = r_s1_data[32*k +: 32];
        assign w_pos  = ~r_s1_neg[k] & ~r_s1_zero[k] & ~r_s1_nan[k];
        assign w_prod = fp_mul(w_x, r_slope);

        always_comb begin
            w_lane = 32'd0;
            if (r_s1_mode == c_mode_pass)
                w_lane = w_x;
            else if (r_s1_nan[k])
                w_lane = c_qnan;
            else if (w_pos) begin
                if (r_s1_mode == c_mode_relu || r_s1_mode == c_mode_leaky)
                    w_lane = w_x;
                else
                    w_lane = (w_x[30:0] > r_clip[30:0]) ? r_clip : w_x;
            end else if (r_s1_neg[k] && r_s1_mode == c_mode_leaky)
                w_lane = w_prod;
        end

        assign w_res[32*k +: 32] = w_lane;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_mode  <= 2'd0;
            r_s1_nan   <= '0;
            r_s1_zero  <= '0;
            r_s1_neg   <= '0;
            r_s2_data  <= '0;
            r_slope    <= SLOPE_RST;
            r_clip     <= CLIP_RST;
        end else begin
            if (w_s1_load) begin
                r_s1_valid <= w_accept;
                if (w_accept) begin
                    r_s1_data <= s.data_in;
                    r_s1_mode <= s.mode;
                    r_s1_nan  <= w_in_nan;
                    r_s1_zero <= w_in_zero;
                    r_s1_neg  <= w_in_neg;
                end
            end
            if (w_s2_load) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid)
                    r_s2_data <= w_res;
            end
            if (cfg_we && cfg_ready) begin
                if (cfg_addr)
                    r_clip <= cfg_wdata;
                else
                    r_slope <= cfg_wdata;
            end
        end
    end

`ifdef ACT_UNIT_STATS_EN
    logic [31:0] r_neg_count;
    logic [5:0]  w_neg_lanes;
    logic [32:0] w_neg_sum;

    always_comb begin
        w_neg_lanes = 6'd0;
        for (int k = 0; k < LANES; k++)
            w_neg_lanes = w_neg_lanes + {5'd0, w_in_neg[k]};
    end

    assign w_neg_sum = {1'b0, r_neg_count} + {27'd0, w_neg_lanes};

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_neg_count <= 32'd0;
        else if (stats_clr)
            r_neg_count <= 32'd0;
        else if (w_accept)
            r_neg_count <= w_neg_sum[32] ? 32'hFFFFFFFF : w_neg_sum[31:0];
    end

    assign neg_count = r_neg_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_act_unit_pipe.sv
//============================================================================
// Module      : tb_act_unit_pipe
// Description : Self-checking bench for act_unit_pipe with a behavioural model.
// Revision    : 1.0
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_act_unit_pipe;
    localparam int LANES = 4;
    localparam int W     = 32 * LANES;

    logic        clk = 1'b0;
    logic        rst_n, cfg_we, cfg_addr;
    logic [31:0] cfg_wdata;
    logic        cfg_ready;
`ifdef ACT_UNIT_STATS_EN
    logic        stats_clr;
    logic [31:0] neg_count;
`endif

    always #5 clk = ~clk;

    act_unit_pipe_if #(.LANES(LANES)) bus ();

    act_unit_pipe #(.LANES(LANES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_ready (cfg_ready),
`ifdef ACT_UNIT_STATS_EN
        .stats_clr (stats_clr),
        .neg_count (neg_count),
`endif
        .s         (bus.slave)
    );

    typedef struct {
        logic [W-1:0] d;
        int           t;
    } beat_t;

    beat_t        q[$];
    logic [31:0]  m_slope, m_clip, m_neg;
    logic [W-1:0] last_out, res;
    logic         last_acc;
    int           cyc, n_pops, n_checks, n_pass, n_fail;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        n_checks++;
        n_fail++;
        $error("FAIL %s observed=timeout expected=handshake", tag);
    endtask

    function automatic real fp_mag(input logic [31:0] x);
        real v;
        int  e;
        v = 1.0 + real'(x[22:0]) / 8388608.0;
        e = int'(x[30:23]) - 127;
        while (e > 0) begin v = v * 2.0; e--; end
        while (e < 0) begin v = v / 2.0; e++; end
        return v;
    endfunction

    // Nearest-even rounding of an exact real magnitude into a normal FP32.
    function automatic logic [31:0] to_fp(input real p, input logic sgn);
        real    m, sc, fl, rem;
        int     e;
        longint ip;
        m = p;
        e = 127;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0)  begin m = m * 2.0; e--; end
        sc  = m * 8388608.0;
        fl  = $floor(sc);
        rem = sc - fl;
        ip  = longint'(fl);
        if (rem > 0.5 || (rem == 0.5 && ip[0])) ip++;
        if (ip == 64'd16777216) begin ip = 64'd8388608; e++; end
        return {sgn, e[7:0], ip[22:0]};
    endfunction

    function automatic logic [31:0] ref_lane(input logic [31:0] x, input logic [1:0] md,
                                             input logic [31:0] slope, input logic [31:0] clip);
        logic nan, zero, pos;
        nan  = (x[30:23] == 8'hFF) && (x[22:0] != 0);
        zero = (x[30:0] == 0);
        pos  = !x[31] && !zero && !nan;
        if (md == 2'd0) return x;
        if (nan)        return 32'h7FC00000;
        if (zero)       return 32'h0;
        case (md)
            2'd1:    return pos ? x : 32'h0;
            2'd2:    return pos ? x : to_fp(fp_mag(x) * fp_mag(slope), x[31] ^ slope[31]);
            default: return !pos ? 32'h0 : ((x[30:0] > clip[30:0]) ? clip : x);
        endcase
    endfunction

    function automatic logic [W-1:0] ref_beat(input logic [W-1:0] d, input logic [1:0] md);
        logic [W-1:0] r;
        for (int k = 0; k < LANES; k++)
            r[32*k +: 32] = ref_lane(d[32*k +: 32], md, m_slope, m_clip);
        return r;
    endfunction

    function automatic int neg_lanes(input logic [W-1:0] d);
        int n = 0;
        logic [31:0] x;
        for (int k = 0; k < LANES; k++) begin
            x = d[32*k +: 32];
            if (x[31] && x[30:0] != 0 && !((x[30:23] == 8'hFF) && (x[22:0] != 0))) n++;
        end
        return n;
    endfunction

    function automatic logic [31:0] rand_lane();
        logic [22:0] m;
        m = 23'($urandom());
        case ($urandom_range(0, 7))
            0:       return {1'($urandom()), 31'd0};
            1:       return {1'($urandom()), 8'hFF, m | 23'd1};
            2:       return 32'h7F800000;
            3, 4:    return {1'b0, 8'($urandom_range(100, 160)), m};
            default: return {1'b1, 8'($urandom_range(110, 140)), m};
        endcase
    endfunction

    function automatic logic [W-1:0] rand_beat();
        logic [W-1:0] d;
        for (int k = 0; k < LANES; k++) d[32*k +: 32] = rand_lane();
        return d;
    endfunction

    // One clock: compare against the model at #1 after the drive point, then advance.
    task automatic tick();
        logic e_in_ready, e_out_valid, e_cfg_ready;
        #1;
        e_in_ready  = (q.size() < 2) || bus.out_ready;
        e_out_valid = (q.size() > 0) && ((cyc - q[0].t) >= 2);
        e_cfg_ready = (q.size() == 0) && !bus.in_valid;
        chk("in_ready",  W'(bus.in_ready),  W'(e_in_ready));
        chk("out_valid", W'(bus.out_valid), W'(e_out_valid));
        chk("cfg_ready", W'(cfg_ready),     W'(e_cfg_ready));
        if (e_out_valid) chk("data_o", bus.data_o, q[0].d);
`ifdef ACT_UNIT_STATS_EN
        chk("neg_count", W'(neg_count), W'(m_neg));
`endif
        last_acc = 1'b0;
        if (!rst_n) begin
            q.delete();
            m_slope = 32'h3DCCCCCD;
            m_clip  = 32'h40C00000;
            m_neg   = 32'd0;
        end else begin
            if (e_out_valid && bus.out_ready) begin
                last_out = bus.data_o;
                void'(q.pop_front());
                n_pops++;
            end
`ifdef ACT_UNIT_STATS_EN
            if (stats_clr) m_neg = 32'd0;
            else if (bus.in_valid && e_in_ready)
                m_neg = (64'(m_neg) + 64'(neg_lanes(bus.data_in)) > 64'hFFFFFFFF)
                        ? 32'hFFFFFFFF : m_neg + 32'(neg_lanes(bus.data_in));
`endif
            if (bus.in_valid && e_in_ready) begin
                q.push_back('{d: ref_beat(bus.data_in, bus.mode), t: cyc});
                last_acc = 1'b1;
            end
            if (cfg_we && e_cfg_ready) begin
                if (cfg_addr) m_clip = cfg_wdata;
                else          m_slope = cfg_wdata;
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_beat(input logic [1:0] md, input logic [W-1:0] d, output logic [W-1:0] r);
        int p0 = n_pops;
        int k  = 0;
        bus.in_valid  = 1'b1;
        bus.mode      = md;
        bus.data_in   = d;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        while (n_pops == p0 && k < 10) begin tick(); k++; end
        if (n_pops == p0) timeout_fail("run_beat");
        r = last_out;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, k, st;
        n_checks = 0; n_pass = 0; n_fail = 0; n_pops = 0; cyc = 0;
        rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = 1'b0; cfg_wdata = 32'd0;
        bus.in_valid = 1'b0; bus.mode = 2'd0; bus.data_in = '0; bus.out_ready = 1'b1;
`ifdef ACT_UNIT_STATS_EN
        stats_clr = 1'b0;
`endif
        m_slope = 32'h3DCCCCCD; m_clip = 32'h40C00000; m_neg = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tick();
        rst_n = 1'b1;
        chk("rst_data_o", bus.data_o, '0);
        tick();

        // Leaky ReLU with the default 0.1 slope
        run_beat(2'd2, {32'h80000000, 32'h00000000, 32'hBF800000, 32'h3F800000}, res);
        chk("leaky_default", res, {32'h00000000, 32'h00000000, 32'hBDCCCCCD, 32'h3F800000});
        tick();

        run_beat(2'd3, {32'hC0000000, 32'h7F800000, 32'h40000000, 32'h40E00000}, res);
        chk("clip_default", res, {32'h00000000, 32'h40C00000, 32'h40000000, 32'h40C00000});

        run_beat(2'd1, {32'h3F800000, 32'h80000000, 32'h3F800000, 32'h7FC00001}, res);
        chk("nan_relu", res, {32'h3F800000, 32'h00000000, 32'h3F800000, 32'h7FC00000});
        run_beat(2'd2, {32'h3F800000, 32'h80000000, 32'h3F800000, 32'h7FC00001}, res);
        chk("nan_leaky", res, {32'h3F800000, 32'h00000000, 32'h3F800000, 32'h7FC00000});
        run_beat(2'd3, {32'h3F800000, 32'h80000000, 32'h3F800000, 32'h7FC00001}, res);
        chk("nan_clip", res, {32'h3F800000, 32'h00000000, 32'h3F800000, 32'h7FC00000});
        run_beat(2'd0, {32'h3F800000, 32'h80000000, 32'h3F800000, 32'h7FC00001}, res);
        chk("pass_raw", res, {32'h3F800000, 32'h80000000, 32'h3F800000, 32'h7FC00001});

        // Ten back-to-back beats with a five-cycle downstream stall in the middle
        p0 = n_pops;
        st = cyc + 3;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.mode     = 2'($urandom_range(0, 3));
            bus.data_in  = rand_beat();
            k = 0;
            do begin
                bus.out_ready = !(cyc >= st && cyc < st + 5);
                tick();
                k++;
            end while (!last_acc && k < 50);
            if (!last_acc) timeout_fail("stream_accept");
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (4) tick();
        chk("stream_count", W'(n_pops - p0), W'(10));

        // Config write while busy is dropped; the idle write lands
        bus.in_valid = 1'b1; bus.mode = 2'd2; bus.data_in = {4{32'h3F800000}};
        tick();
        bus.in_valid = 1'b0;
        cfg_we = 1'b1; cfg_addr = 1'b0; cfg_wdata = 32'h3F000000;
        tick();
        cfg_we = 1'b0;
        repeat (3) tick();
        run_beat(2'd2, {4{32'hBF800000}}, res);
        chk("slope_busy_ignored", res, {4{32'hBDCCCCCD}});
        cfg_we = 1'b1;
        tick();
        cfg_we = 1'b0;
        run_beat(2'd2, {4{32'hBF800000}}, res);
        chk("slope_idle_write", res, {4{32'hBF000000}});

`ifdef ACT_UNIT_STATS_EN
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        tick();
`endif

        // Randomised traffic, back-pressure and config writes
        for (int i = 0; i < 400; i++) begin
            bus.in_valid  = (i < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) < 3);
            bus.mode      = 2'($urandom_range(0, 3));
            bus.data_in   = rand_beat();
            bus.out_ready = ($urandom_range(0, 9) < 7);
            cfg_we        = ($urandom_range(0, 4) == 0);
            cfg_addr      = 1'($urandom());
            cfg_wdata     = cfg_addr ? {1'b0, 8'($urandom_range(120, 140)), 23'($urandom())}
                                     : {1'($urandom()), 8'($urandom_range(110, 140)), 23'($urandom())};
            tick();
        end
        cfg_we = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        repeat (3) tick();

        // Reset with two beats in flight
        bus.in_valid = 1'b1; bus.mode = 2'd1; bus.data_in = {4{32'h3F800000}};
        tick();
        tick();
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst_flush_valid", W'(bus.out_valid), W'(0));
        repeat (3) tick();
        run_beat(2'd2, {4{32'hBF800000}}, res);
        chk("rst_slope", res, {4{32'hBDCCCCCD}});
        run_beat(2'd3, {4{32'h40E00000}}, res);
        chk("rst_clip", res, {4{32'h40C00000}});
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

`default_nettype wire
